// File: rtl/copier_job_scheduler.sv
// Round-robin scheduler sharing one copier engine between NREQ requesters, with fault pause and watchdog abort.
// Optional per-requester page quota when COPY_QUOTA_EN is defined (adds the quota_empty output).
module copier_job_scheduler #(
  parameter int NREQ        = 2,
  parameter int QBITS       = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int QUOTA       = 7
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*QBITS-1:0] req_qty,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  ack_err,
  output logic                  cop_start,
  output logic [QBITS-1:0]      cop_qty,
  output logic                  cop_abort,
  input  logic                  cop_done,
  input  logic                  cop_fault,
  output logic                  timeout_flag,
  output logic [7:0]            pages_total,
  output logic [2:0]            state_code
`ifdef COPY_QUOTA_EN
  ,
  output logic [NREQ-1:0]       quota_empty
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    idx_reg;
  logic [QBITS-1:0] qty_reg;
  logic             err_reg;
  logic [WW-1:0]    watchdog;

  logic [QBITS-1:0] qty_arr [NREQ];
  logic [NREQ-1:0]  elig;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    rr_next;
  logic             found;
  logic [8:0]       pages_sum;
  logic [7:0]       pages_sat;

`ifdef COPY_QUOTA_EN
  localparam int RW = $clog2(QUOTA + 1);
  localparam int CW = RW + QBITS;
  logic [RW-1:0] remaining [NREQ];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_elig
      assign qty_arr[gi] = req_qty[gi*QBITS +: QBITS];
`ifdef COPY_QUOTA_EN
      assign elig[gi] = req[gi] && (qty_arr[gi] != '0) &&
                        (CW'(qty_arr[gi]) <= CW'(remaining[gi]));
`else
      assign elig[gi] = req[gi] && (qty_arr[gi] != '0);
`endif
    end
  endgenerate

  // Search starts at the round-robin pointer and wraps modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      logic [IW-1:0] cand;
      c = int'(rr_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      cand = IW'(c);
      if (!found && elig[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    if (int'(winner) == NREQ - 1) rr_next = '0;
    else                          rr_next = winner + 1'b1;
  end

  assign pages_sum  = {1'b0, pages_total} + 9'(qty_reg);
  assign pages_sat  = pages_sum[8] ? 8'hFF : pages_sum[7:0];
  assign state_code = state;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      idx_reg      <= '0;
      qty_reg      <= '0;
      err_reg      <= 1'b0;
      watchdog     <= '0;
      grant        <= '0;
      ack          <= '0;
      ack_err      <= 1'b0;
      cop_start    <= 1'b0;
      cop_qty      <= '0;
      cop_abort    <= 1'b0;
      timeout_flag <= 1'b0;
      pages_total  <= '0;
    end else begin
      cop_start <= 1'b0;
      cop_abort <= 1'b0;
      ack       <= '0;
      ack_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            idx_reg <= winner;
            qty_reg <= qty_arr[winner];
            err_reg <= 1'b0;
            grant   <= NREQ'(1) << winner;
            rr_ptr  <= rr_next;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cop_start <= 1'b1;
          cop_qty   <= qty_reg;
          watchdog  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Completion beats both a fault and a simultaneous watchdog expiry.
          if (cop_done) begin
            pages_total <= pages_sat;
            state       <= DONE;
          end else if (cop_fault) begin
            state <= PAUSED;
          end else if (watchdog == WW'(TIMEOUT_CYC - 1)) begin
            cop_abort    <= 1'b1;
            timeout_flag <= 1'b1;
            err_reg      <= 1'b1;
            state        <= DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        PAUSED: begin
          if (cop_done) begin
            pages_total <= pages_sat;
            state       <= DONE;
          end else if (!cop_fault) begin
            state <= WAIT;
          end
        end
        DONE: begin
          ack     <= grant;
          ack_err <= err_reg;
          grant   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COPY_QUOTA_EN
  // Only successful jobs are charged against the requester's quota.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_quota
      always_ff @(posedge clk_2) begin
        if (reset) begin
          remaining[gi]   <= RW'(QUOTA);
          quota_empty[gi] <= 1'b0;
        end else if (state == DONE && !err_reg && idx_reg == IW'(gi)) begin
          remaining[gi]   <= remaining[gi] - RW'(qty_reg);
          quota_empty[gi] <= (remaining[gi] == RW'(qty_reg));
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_copier_job_scheduler.sv
// Bench for copier_job_scheduler: directed scenarios plus random jobs against a job-level reference model.
// Build with COPY_QUOTA_EN defined to also exercise the quota feature.
module tb_copier_job_scheduler;
  localparam int NREQ        = 2;
  localparam int QBITS       = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int QUOTA       = 7;

  logic                  clk_2 = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*QBITS-1:0] req_qty;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  ack_err;
  logic                  cop_start;
  logic [QBITS-1:0]      cop_qty;
  logic                  cop_abort;
  logic                  cop_done;
  logic                  cop_fault;
  logic                  timeout_flag;
  logic [7:0]            pages_total;
  logic [2:0]            state_code;
`ifdef COPY_QUOTA_EN
  logic [NREQ-1:0]       quota_empty;
`endif

  copier_job_scheduler #(
    .NREQ(NREQ), .QBITS(QBITS), .TIMEOUT_CYC(TIMEOUT_CYC), .QUOTA(QUOTA)
  ) dut (
    .clk_2(clk_2), .reset(reset), .req(req), .req_qty(req_qty),
    .grant(grant), .ack(ack), .ack_err(ack_err),
    .cop_start(cop_start), .cop_qty(cop_qty), .cop_abort(cop_abort),
    .cop_done(cop_done), .cop_fault(cop_fault),
    .timeout_flag(timeout_flag), .pages_total(pages_total), .state_code(state_code)
`ifdef COPY_QUOTA_EN
    , .quota_empty(quota_empty)
`endif
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;
  int exp_pages;
  int rr;
  int rem [NREQ];
  bit exp_flag;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic model_reset();
    exp_pages = 0;
    exp_flag  = 1'b0;
    rr        = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef COPY_QUOTA_EN
      rem[i] = QUOTA;
`else
      rem[i] = 1000;
`endif
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    req_qty   = '0;
    cop_done  = 1'b0;
    cop_fault = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Round-robin rule: first eligible index at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input logic [NREQ*QBITS-1:0] q, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      int qi;
      i  = (ptr + k) % NREQ;
      qi = int'(q[i*QBITS +: QBITS]);
      if (r[i] && qi != 0 && qi <= rem[i]) return i;
    end
    return -1;
  endfunction

  // mode 0: done after d WAIT cycles; 1: fault for d cycles then done; 2: no done (timeout); 3: done and fault together.
  task automatic run_job(input int idx, input int qty, input int mode, input int d, input bit drop);
    int n;
    bit err;
    err = (mode == 2);
    tick();
    check("grant", 32'(grant), 1 << idx);
    check("state_issue", 32'(state_code), 1);
    rr = (idx + 1) % NREQ;
    if (drop) req[idx] = 1'b0;
    tick();
    check("cop_start", 32'(cop_start), 1);
    check("cop_qty", 32'(cop_qty), qty);
    if (mode == 0 || mode == 3) begin
      repeat (d) tick();
      cop_done = 1'b1;
      if (mode == 3) cop_fault = 1'b1;
      tick();
      cop_done  = 1'b0;
      cop_fault = 1'b0;
    end else if (mode == 1) begin
      cop_fault = 1'b1;
      tick();
      check("state_paused", 32'(state_code), 3);
      n = 0;
      repeat (d) begin
        tick();
        if (cop_abort || state_code != 3'd3) n++;
      end
      check("pause_hold", n, 0);
      cop_fault = 1'b0;
      tick();
      check("state_resume", 32'(state_code), 2);
      repeat (9) tick();
      cop_done = 1'b1;
      tick();
      cop_done = 1'b0;
    end else begin
      n = 0;
      while (!cop_abort && n < 200) begin
        tick();
        n++;
      end
      check("timeout_cycles", n, TIMEOUT_CYC);
    end
    check("state_done", 32'(state_code), 4);
    check("abort_at_done", 32'(cop_abort), err ? 1 : 0);
    if (err) exp_flag = 1'b1;
    else begin
      exp_pages = (exp_pages + qty > 255) ? 255 : exp_pages + qty;
      rem[idx]  = rem[idx] - qty;
    end
    tick();
    check("ack", 32'(ack), 1 << idx);
    check("ack_err", 32'(ack_err), err ? 1 : 0);
    check("grant_clear", 32'(grant), 0);
    check("state_idle", 32'(state_code), 0);
    check("abort_one_cycle", 32'(cop_abort), 0);
    check("pages_total", 32'(pages_total), exp_pages);
    check("timeout_flag", 32'(timeout_flag), exp_flag ? 1 : 0);
`ifdef COPY_QUOTA_EN
    check("quota_empty", 32'(quota_empty[idx]), (rem[idx] == 0) ? 1 : 0);
`endif
    $display("job req=%0d qty=%0d mode=%0d d=%0d err=%0d pages=%0d", idx, qty, mode, d, err, pages_total);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_ack_err", 32'(ack_err), 0);
    check("rst_cop_start", 32'(cop_start), 0);
    check("rst_cop_qty", 32'(cop_qty), 0);
    check("rst_cop_abort", 32'(cop_abort), 0);
    check("rst_flag", 32'(timeout_flag), 0);
    check("rst_pages", 32'(pages_total), 0);
    check("rst_state", 32'(state_code), 0);

    // Single job, done 5 cycles after start.
    req = 2'b01; req_qty = 4'b0010;
    run_job(0, 2, 0, 5, 1'b1);
    tick();
    check("ack_one_cycle", 32'(ack), 0);

    // Two requesters held high alternate.
    do_reset();
    req = 2'b11; req_qty = 4'b1101;
    for (int j = 0; j < 4; j++) begin
      int w;
      w = pick(req, req_qty, rr);
      check("rr_order", w, j % 2);
      run_job(w, (w == 0) ? 1 : 3, 0, 2, 1'b0);
    end
    check("pages_after_4", 32'(pages_total), 8);
    req = '0;

    // Long fault pause: watchdog frozen, no abort.
    tick();
    req = 2'b01; req_qty = 4'b0010;
    run_job(0, 2, 1, 100, 1'b1);

    // Done on the last watchdog cycle wins over abort.
    req = 2'b01; req_qty = 4'b0001;
    run_job(0, 1, 0, TIMEOUT_CYC - 1, 1'b1);

    // Watchdog abort.
    req = 2'b10; req_qty = 4'b1100;
    run_job(1, 3, 2, 0, 1'b1);

    // Zero quantity never granted.
    req = 2'b10; req_qty = 4'b0011;
    repeat (5) begin
      tick();
      check("zero_qty_no_grant", 32'(grant), 0);
    end

    // Reset in the middle of WAIT drops the job silently.
    req = 2'b01; req_qty = 4'b0010;
    tick();
    tick();
    tick();
    reset = 1'b1;
    req   = '0;
    tick();
    check("midrst_grant", 32'(grant), 0);
    check("midrst_state", 32'(state_code), 0);
    check("midrst_pages", 32'(pages_total), 0);
    check("midrst_flag", 32'(timeout_flag), 0);
    check("midrst_abort", 32'(cop_abort), 0);
    check("midrst_start", 32'(cop_start), 0);
    reset = 1'b0;
    model_reset();
    tick();
    check("midrst_no_ack", 32'(ack), 0);
    check("midrst_no_grant", 32'(grant), 0);

`ifdef COPY_QUOTA_EN
    // Quota: 3+3 leaves 1, a further qty 3 is refused, qty 1 empties it.
    do_reset();
    req = 2'b01; req_qty = 4'b0011;
    run_job(0, 3, 0, 2, 1'b1);
    req = 2'b01; req_qty = 4'b0011;
    run_job(0, 3, 0, 2, 1'b1);
    req = 2'b01; req_qty = 4'b0011;
    repeat (4) begin
      tick();
      check("quota_refused", 32'(grant), 0);
    end
    req_qty = 4'b0001;
    run_job(0, 1, 0, 1, 1'b1);
    check("quota_empty_final", 32'(quota_empty[0]), 1);
`else
    // pages_total saturates at 255.
    do_reset();
    req = 2'b10; req_qty = 4'b1100;
    repeat (90) run_job(1, 3, 0, 0, 1'b0);
    check("pages_saturated", 32'(pages_total), 255);
    req = '0;
`endif

    // Random jobs against the model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int w;
      int mode;
      int d;
      req     = NREQ'($urandom);
      req_qty = (NREQ*QBITS)'($urandom);
      w = pick(req, req_qty, rr);
      if (w < 0) begin
        repeat (3) begin
          tick();
          check("rand_no_grant", 32'(grant), 0);
        end
      end else begin
        case ($urandom_range(0, 7))
          0:       mode = 2;
          1, 2:    mode = 1;
          3:       mode = 3;
          default: mode = 0;
        endcase
        d = (mode == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, TIMEOUT_CYC - 1));
        run_job(w, int'(req_qty[w*QBITS +: QBITS]), mode, d, 1'($urandom));
      end
    end
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/copier_job_scheduler.md
Name: copier_job_scheduler

Overview:
- Shares one copier engine between NREQ requesters (board switches or user-side FSMs).
- Arbitrates round-robin and issues one job to the engine: a start pulse plus a page quantity.
- Waits for engine completion, pauses while the engine reports a fault (no paper or jam), and aborts on a watchdog timeout.
- Exposes the grant, ack and status signals used by the LED and 7-segment display logic.

Parameters:
- NREQ, 2: number of requesters (2..4).
- QBITS, 2: width of the page quantity per job.
- TIMEOUT_CYC, 64: maximum non-fault cycles in WAIT before the job is aborted.
- QUOTA, 7: pages allowed per requester between resets; used only with COPY_QUOTA_EN.

Ports:
- clk_2  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  job request per requester, level.
- req_qty  in  NREQ*QBITS  page quantity, requester i at [i*QBITS +: QBITS].
- grant  out  NREQ  one-hot, marks the requester whose job is in flight.
- ack  out  NREQ  one-cycle pulse when a job ends, successful or aborted.
- ack_err  out  1  one-cycle pulse coincident with ack when the job was aborted.
- cop_start  out  1  one-cycle start pulse to the copier engine.
- cop_qty  out  QBITS  quantity for the engine, valid while cop_start=1.
- cop_abort  out  1  one-cycle pulse telling the engine to drop the current job.
- cop_done  in  1  engine pulse: all pages of the job are out.
- cop_fault  in  1  engine level: no paper or jam.
- timeout_flag  out  1  sticky; set on any abort.
- pages_total  out  8  pages completed, saturating at 255.
- state_code  out  3  current FSM state, for the SEG decoder.

Behaviour:
- All outputs are registered. Reset values: grant=0, ack=0, ack_err=0, cop_start=0, cop_qty=0, cop_abort=0, timeout_flag=0, pages_total=0, state_code=IDLE(0). RR pointer=0, watchdog=0.
- Eligibility: requester i is eligible when req[i]=1 and req_qty slice ≠0. Zero-quantity requests are never granted.
- Handshake: a requester holds req and qty stable until its ack. Qty is latched at grant, so later changes are ignored. Dropping req mid-job does not cancel the job; ack still pulses.
- States (code):
  - IDLE(0): if any requester is eligible, pick the first eligible index at or after the RR pointer (modulo NREQ). Latch the index and qty, set grant, go to ISSUE. Next cycle the RR pointer becomes winner+1 mod NREQ.
  - ISSUE(1): cop_start=1 and cop_qty=latched qty for exactly one cycle. Clear watchdog, go to WAIT.
  - WAIT(2):
    - cop_done=1: pages_total += qty (saturating), go to DONE.
    - else cop_fault=1: go to PAUSED.
    - else watchdog+1. When watchdog reaches TIMEOUT_CYC-1: cop_abort=1 for one cycle, timeout_flag=1, go to DONE with the error marked.
  - PAUSED(3): watchdog frozen. When cop_fault=0, go to WAIT with watchdog retained. cop_done while paused is accepted and treated as in WAIT.
  - DONE(4): ack[grant idx]=1, ack_err=error marker, grant cleared; go to IDLE. Next arbitration occurs in IDLE the following cycle, giving a minimum 1 idle cycle between jobs.
- Latency: req rising in IDLE gives grant after 1 cycle and cop_start after 2.
- Simultaneous cop_done and watchdog expiry: done wins; no abort.
- Simultaneous cop_done and cop_fault: done wins.
- Reset at any point returns to IDLE within one cycle. Any in-flight job is dropped without ack, and cop_abort is not asserted; the engine is reset separately.
- Arithmetic: the watchdog is clog2(TIMEOUT_CYC) bits. pages_total addition saturates at 255 with no wrap.

Optional Feature:
- COPY_QUOTA_EN defined: one remaining-quota counter per requester, reset to QUOTA.
  - A requester is eligible only if qty ≤ remaining.
  - The counter is decremented by qty at DONE without error; aborted jobs are not charged.
  - An ineligible-by-quota request is ignored (never granted) until reset.
  - Adds output quota_empty [NREQ], reset 0, set when remaining=0.
- Macro undefined: no quota counters, no quota_empty port, eligibility as above.

Test Plan:
- Reset, then req[0]=1 with qty=2; pulse cop_done 5 cycles after cop_start → grant=01 next cycle, cop_start=1 with cop_qty=2 a cycle later, ack[0] pulse, pages_total=2, state_code back to 0.
- req=11, qty0=1, qty1=3, held high, done after each start → grant order 0,1,0,1; pages_total after 4 jobs = 8.
- Job started; cop_fault=1 for 100 cycles, then 0, cop_done after 10 → no abort, state_code=3 during the fault, ack_err=0.
- Job started, no done and no fault, TIMEOUT_CYC=64 → cop_abort pulse on the 64th WAIT cycle, ack with ack_err=1, timeout_flag=1 until reset, pages_total unchanged.
- req[1]=1 with qty=0 → no grant, ever; reset asserted during WAIT → all outputs back to reset values next cycle, no ack.
- With COPY_QUOTA_EN and QUOTA=7: requester 0 runs jobs of qty 3,3 → third request with qty 3 is never granted and quota_empty[0]=0 (remaining 1); a qty 1 job is granted, then quota_empty[0]=1.
